// File: rtl/traffic_pkg.sv
// traffic_pkg
//   Shared definitions for the NS/EW intersection phase scheduler: phase
//   encoding, one-hot lamp encoding {G,Y,R}, default phase timings and the
//   lamp decode helpers used by traffic_phase_scheduler.
//   No ports (package).
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_GRN   = 3'd0,
        NS_YEL   = 3'd1,
        AR_TO_EW = 3'd2,
        EW_GRN   = 3'd3,
        EW_YEL   = 3'd4,
        AR_TO_NS = 3'd5
    } phase_e;

    // Lamp vectors are ordered {G,Y,R}.
    localparam logic [2:0] LIGHT_G = 3'b100;
    localparam logic [2:0] LIGHT_Y = 3'b010;
    localparam logic [2:0] LIGHT_R = 3'b001;

    localparam int GREEN_MIN_DEF = 8;
    localparam int GREEN_MAX_DEF = 20;
    localparam int YELLOW_T_DEF  = 3;
    localparam int ALLRED_T_DEF  = 1;
    localparam int WALK_T_DEF    = 6;
    localparam int CNT_W_DEF     = 5;

    function automatic logic [2:0] ns_light(input phase_e s);
        case (s)
            NS_GRN:  return LIGHT_G;
            NS_YEL:  return LIGHT_Y;
            default: return LIGHT_R;
        endcase
    endfunction

    function automatic logic [2:0] ew_light(input phase_e s);
        case (s)
            EW_GRN:  return LIGHT_G;
            EW_YEL:  return LIGHT_Y;
            default: return LIGHT_R;
        endcase
    endfunction

endpackage

// File: rtl/traffic_phase_timer.sv
// phase_timer
//   Cycles-in-phase counter for the traffic scheduler. Synchronous clear has
//   priority; while enabled it counts up by one per cycle, and when saturation
//   is enabled it holds once it reaches sat_val_i instead of wrapping.
//   Ports:
//     clk_i      clock, rising edge
//     clr_i      synchronous clear (count -> 0)
//     en_i       count enable
//     sat_en_i   hold at sat_val_i instead of incrementing past it
//     sat_val_i  saturation value
//     cnt_o      current count
module phase_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             sat_en_i,
    input  logic [CNT_W-1:0] sat_val_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !(sat_en_i && (cnt_q >= sat_val_i))) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
//   Demand-driven NS/EW light sequencer. Holds a green until the cross street
//   asks for service (after a minimum green), then runs yellow and an all-red
//   clearance before handing over. Cross-street requests seen outside that
//   street's green are latched until it is served.
//   Optional feature macro: PED_REQ_EN -- pedestrian button; a pending walk
//   request counts as cross demand and stretches the next all-red to WALK_T
//   with the walk lamp lit. Without it ped_req_i is ignored, ped_walk_o is 0.
//   Ports:
//     clk_i                   clock, rising edge
//     rst_i                   synchronous, active-high reset
//     ns_req_i / ew_req_i     vehicle sensors (level)
//     ped_req_i               pedestrian button (pulse)
//     ns_{g,y,r}_o            NS lamps, registered, one-hot
//     ew_{g,y,r}_o            EW lamps, registered, one-hot
//     ped_walk_o              walk lamp, registered
//     state_o                 current phase (debug)
//     timer_o                 cycles spent in current phase (debug)
//
//   state    | meaning
//   NS_GRN   | NS green, EW red
//   NS_YEL   | NS yellow, EW red
//   AR_TO_EW | both red, clearing towards EW (walk when served)
//   EW_GRN   | EW green, NS red
//   EW_YEL   | EW yellow, NS red
//   AR_TO_NS | both red, clearing towards NS (walk when served)
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int GREEN_MIN = GREEN_MIN_DEF,
    parameter int GREEN_MAX = GREEN_MAX_DEF,
    parameter int YELLOW_T  = YELLOW_T_DEF,
    parameter int ALLRED_T  = ALLRED_T_DEF,
    parameter int WALK_T    = WALK_T_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ns_req_i,
    input  logic             ew_req_i,
    input  logic             ped_req_i,
    output logic             ns_g_o,
    output logic             ns_y_o,
    output logic             ns_r_o,
    output logic             ew_g_o,
    output logic             ew_y_o,
    output logic             ew_r_o,
    output logic             ped_walk_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] timer_o
);

    localparam logic [CNT_W-1:0] GRN_LAST = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] SAT_VAL  = CNT_W'(GREEN_MAX - 1);

    phase_e           state_q, state_d;
    logic             pend_ns_q, pend_ns_d, pend_ew_q, pend_ew_d;
    logic             walk_q;
    logic             ped_dem;
    logic             xreq_ns, xreq_ew;
    logic             in_green, in_ar, next_ar;
    logic [CNT_W-1:0] timer_q;
    logic [CNT_W-1:0] ar_last;

    assign in_green = (state_q == NS_GRN) || (state_q == EW_GRN);
    assign in_ar    = (state_q == AR_TO_EW) || (state_q == AR_TO_NS);
    assign next_ar  = (state_d == AR_TO_EW) || (state_d == AR_TO_NS);

`ifdef PED_REQ_EN
    localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(WALK_T - 1);

    logic pend_ped_q, pend_ped_d, walk_d;

    assign ped_dem = pend_ped_q | ped_req_i;
    assign ar_last = walk_q ? WALK_LAST : AR_LAST;

    // A pending request is consumed when the all-red it lights starts; a
    // press during that walk (or on the same edge) latches for the next one.
    always_comb begin
        pend_ped_d = pend_ped_q;
        walk_d     = 1'b0;
        if (next_ar && !in_ar) begin
            pend_ped_d = 1'b0;
            walk_d     = pend_ped_q;
        end else if (next_ar) begin
            walk_d     = walk_q;
        end
        if (ped_req_i) begin
            pend_ped_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_ped_q <= 1'b0;
            walk_q     <= 1'b0;
        end else begin
            pend_ped_q <= pend_ped_d;
            walk_q     <= walk_d;
        end
    end
`else
    localparam int unused_walk_t = WALK_T;
    logic unused_ped;

    assign unused_ped = ped_req_i;
    assign ped_dem    = 1'b0;
    assign walk_q     = 1'b0;
    assign ar_last    = AR_LAST;
`endif

    // Same-cycle sensing: a live request counts as much as a latched one.
    assign xreq_ew = pend_ew_q | ew_req_i | ped_dem;
    assign xreq_ns = pend_ns_q | ns_req_i | ped_dem;

    always_comb begin
        state_d = state_q;
        case (state_q)
            NS_GRN:   if (timer_q >= GRN_LAST && xreq_ew) state_d = NS_YEL;
            NS_YEL:   if (timer_q == YEL_LAST)            state_d = AR_TO_EW;
            AR_TO_EW: if (timer_q == ar_last)             state_d = EW_GRN;
            EW_GRN:   if (timer_q >= GRN_LAST && xreq_ns) state_d = EW_YEL;
            EW_YEL:   if (timer_q == YEL_LAST)            state_d = AR_TO_NS;
            AR_TO_NS: if (timer_q == ar_last)             state_d = NS_GRN;
            default:                                      state_d = NS_GRN;
        endcase
    end

    // Entering a street's green clears its latch, overriding a same-cycle set.
    always_comb begin
        pend_ew_d = pend_ew_q | (ew_req_i && (state_q != EW_GRN));
        pend_ns_d = pend_ns_q | (ns_req_i && (state_q != NS_GRN));
        if (state_d == EW_GRN && state_q != EW_GRN) pend_ew_d = 1'b0;
        if (state_d == NS_GRN && state_q != NS_GRN) pend_ns_d = 1'b0;
    end

    // Lamps decode the next state so they switch on the same edge as state_q.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q                  <= NS_GRN;
            pend_ns_q                <= 1'b0;
            pend_ew_q                <= 1'b0;
            {ns_g_o, ns_y_o, ns_r_o} <= LIGHT_G;
            {ew_g_o, ew_y_o, ew_r_o} <= LIGHT_R;
        end else begin
            state_q                  <= state_d;
            pend_ns_q                <= pend_ns_d;
            pend_ew_q                <= pend_ew_d;
            {ns_g_o, ns_y_o, ns_r_o} <= ns_light(state_d);
            {ew_g_o, ew_y_o, ew_r_o} <= ew_light(state_d);
        end
    end

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i     (clk_i),
        .clr_i     (rst_i || (state_d != state_q)),
        .en_i      (1'b1),
        .sat_en_i  (in_green),
        .sat_val_i (SAT_VAL),
        .cnt_o     (timer_q)
    );

    assign ped_walk_o = walk_q;
    assign state_o    = state_q;
    assign timer_o    = timer_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
module tb_traffic_phase_scheduler;

    localparam int CNT_W     = 5;
    localparam int GREEN_MIN = 8;
    localparam int GREEN_MAX = 20;
    localparam int YELLOW_T  = 3;
    localparam int ALLRED_T  = 1;
    localparam int WALK_T    = 6;

    logic clk = 1'b0;
    logic rst = 1'b1, ns_req = 1'b0, ew_req = 1'b0, ped_req = 1'b0;
    logic ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, ped_walk;
    logic [2:0]       state;
    logic [CNT_W-1:0] timer;

    always #5 clk = ~clk;

    traffic_phase_scheduler dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .ns_req_i   (ns_req),
        .ew_req_i   (ew_req),
        .ped_req_i  (ped_req),
        .ns_g_o     (ns_g),
        .ns_y_o     (ns_y),
        .ns_r_o     (ns_r),
        .ew_g_o     (ew_g),
        .ew_y_o     (ew_y),
        .ew_r_o     (ew_r),
        .ped_walk_o (ped_walk),
        .state_o    (state),
        .timer_o    (timer)
    );

    typedef struct packed {
        logic [2:0]       st;
        logic [CNT_W-1:0] tmr;
        logic [2:0]       ns;
        logic [2:0]       ew;
        logic             walk;
        logic             was_rst;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: phase index walks 0..5 around the ring, age counts
    // cycles since the phase began (unbounded; the timer display saturates).
    int m_ph, m_age;
    bit m_pns, m_pew, m_pped, m_walk;

    function automatic logic [2:0] lamp(input int ph, input int green_ph);
        logic [2:0] v;
        if (ph == green_ph)          v = 3'b100;
        else if (ph == green_ph + 1) v = 3'b010;
        else                         v = 3'b001;
        return v;
    endfunction

    task automatic model_step(input bit r, input bit n, input bit e, input bit p);
        bit adv, xns, xew, pd, ar_entry;
        int nxt;
        if (r) begin
            m_ph = 0; m_age = 0; m_pns = 0; m_pew = 0; m_pped = 0; m_walk = 0;
        end else begin
            pd = 0;
`ifdef PED_REQ_EN
            pd = m_pped | p;
`endif
            xew = m_pew | e | pd;
            xns = m_pns | n | pd;
            if (m_ph == 0)                   adv = (m_age >= GREEN_MIN - 1) && xew;
            else if (m_ph == 3)              adv = (m_age >= GREEN_MIN - 1) && xns;
            else if (m_ph == 1 || m_ph == 4) adv = (m_age == YELLOW_T - 1);
            else                             adv = (m_age == (m_walk ? WALK_T - 1 : ALLRED_T - 1));
            nxt = adv ? (m_ph + 1) % 6 : m_ph;
            if (e && m_ph != 3) m_pew = 1;
            if (n && m_ph != 0) m_pns = 1;
            if (adv && nxt == 3) m_pew = 0;
            if (adv && nxt == 0) m_pns = 0;
            ar_entry = adv && (nxt == 2 || nxt == 5);
`ifdef PED_REQ_EN
            if (ar_entry) begin
                m_walk = m_pped;
                m_pped = 0;
            end else if (adv) begin
                m_walk = 0;
            end
            if (p) m_pped = 1;
`else
            if (ar_entry || p) m_walk = 0;
`endif
            m_age = adv ? 0 : m_age + 1;
            m_ph  = nxt;
        end
    endtask

    function automatic exp_t model_out(input bit r);
        exp_t x;
        int t;
        t = m_age;
        if ((m_ph == 0 || m_ph == 3) && t > GREEN_MAX - 1) t = GREEN_MAX - 1;
        x.st      = 3'(m_ph);
        x.tmr     = CNT_W'(t);
        x.ns      = lamp(m_ph, 0);
        x.ew      = lamp(m_ph, 3);
        x.walk    = m_walk;
        x.was_rst = r;
        return x;
    endfunction

    task automatic cyc(input bit r, input bit n, input bit e, input bit p);
        @(negedge clk);
        rst = r; ns_req = n; ew_req = e; ped_req = p;
        model_step(r, n, e, p);
        exp_q.push_back(model_out(r));
    endtask

    // Directed spot checks against fixed values; sampled after the edge.
    task automatic chk(input string nm, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, want);
        end
    endtask

    task automatic settle;
        @(posedge clk);
        #3;
    endtask

    // Monitor: every cycle the DUT shows a new output set; pop and compare.
    initial begin
        exp_t e;
        logic prev_ns_g, prev_ew_g;
        logic [14:0] act, want;
        prev_ns_g = 1'b0;
        prev_ew_g = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e    = exp_q.pop_front();
                act  = {state, timer, ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, ped_walk};
                want = {e.st, e.tmr, e.ns, e.ew, e.walk};
                checks++;
                if (act !== want) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t got st=%0d tmr=%0d ns=%b ew=%b walk=%b want st=%0d tmr=%0d ns=%b ew=%b walk=%b",
                             $time, state, timer, {ns_g, ns_y, ns_r}, {ew_g, ew_y, ew_r}, ped_walk,
                             e.st, e.tmr, e.ns, e.ew, e.walk);
                end
                checks++;
                if (($countones({ns_g, ns_y, ns_r}) != 1) || ($countones({ew_g, ew_y, ew_r}) != 1)
                    || (ns_g && ew_g)) begin
                    errors++;
                    $display("FAIL lamp_onehot t=%0t got ns=%b ew=%b want one-hot, not both green",
                             $time, {ns_g, ns_y, ns_r}, {ew_g, ew_y, ew_r});
                end
                checks++;
                if (!e.was_rst && ((prev_ns_g && !(ns_g || ns_y)) || (prev_ew_g && !(ew_g || ew_y)))) begin
                    errors++;
                    $display("FAIL yellow_before_red t=%0t got ns=%b ew=%b after green want green or yellow",
                             $time, {ns_g, ns_y, ns_r}, {ew_g, ew_y, ew_r});
                end
                prev_ns_g = ns_g;
                prev_ew_g = ew_g;
            end
        end
    end

    initial begin
        // Idle after reset: NS green forever, timer saturates at GREEN_MAX-1.
        repeat (2) cyc(1, 0, 0, 0);
        repeat (50) cyc(0, 0, 0, 0);
        settle();
        chk("idle_state", state, 0);
        chk("idle_timer_sat", timer, GREEN_MAX - 1);
        chk("idle_ns_g", ns_g, 1);
        chk("idle_ew_r", ew_r, 1);

        // One-cycle EW request at cycle 2 -> EW green from cycle 12.
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 8; k++) cyc(0, 0, (k == 2), 0);
        settle();
        chk("ns_yel_at_8", state, 1);
        for (int k = 8; k < 12; k++) cyc(0, 0, 0, 0);
        settle();
        chk("ew_grn_at_12", state, 3);
        chk("ew_grn_timer0", timer, 0);

        // EW pulse during NS yellow, NS held: EW green 12..19, yellow, AR, NS.
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 24; k++) cyc(0, (k >= 9), (k == 2 || k == 9), 0);
        settle();
        chk("ns_grn_at_24", state, 0);

        // Reset in EW_YEL with timer 1, latched EW demand pending.
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 21; k++) cyc(0, (k >= 9), (k == 2 || k == 20), 0);
        settle();
        chk("ew_yel_state", state, 4);
        chk("ew_yel_timer", timer, 1);
        cyc(1, 0, 0, 0);
        settle();
        chk("rst_state", state, 0);
        chk("rst_timer", timer, 0);
        chk("rst_ns_g", ns_g, 1);
        repeat (20) cyc(0, 0, 0, 0);
        settle();
        chk("rst_pend_cleared", state, 0);

`ifdef PED_REQ_EN
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 12; k++) cyc(0, 0, 0, (k == 3));
        settle();
        chk("ped_ar_state", state, 2);
        chk("ped_walk_on", ped_walk, 1);
        for (int k = 12; k < 17; k++) cyc(0, 0, 0, 0);
        settle();
        chk("ped_ew_grn_at_17", state, 3);
        chk("ped_walk_off", ped_walk, 0);
`else
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 20; k++) cyc(0, 0, 0, (k == 3));
        settle();
        chk("ped_ignored_state", state, 0);
        chk("ped_ignored_walk", ped_walk, 0);
`endif

        // Randomized traffic with occasional resets.
        begin
            bit n_lvl, e_lvl;
            n_lvl = 0;
            e_lvl = 0;
            for (int k = 0; k < 3000; k++) begin
                if ($urandom_range(0, 9) == 0) n_lvl = ~n_lvl;
                if ($urandom_range(0, 9) == 0) e_lvl = ~e_lvl;
                cyc(($urandom_range(0, 299) == 0), n_lvl, e_lvl, ($urandom_range(0, 39) == 0));
            end
        end
        cyc(0, 0, 0, 0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #5;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
